mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the 8-bit pipelined MIPS core.
- Consumes EX/MEM register outputs and performs the data-memory store or read.
- Selects write-back data (ALU / memory / shifter), exposes MEM-stage forwarding data, and registers the result for the register-file write port.
- Contains the data memory (ADDR_W-bit address, 8-bit word).

Parameters:
- ADDR_W, 8, data-memory address width; depth = 2**ADDR_W words, address = EX_MEM_alu_out[ADDR_W-1:0].
- REG_ADDR_W, 3, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold MEM/WB register; suppress store.
- flush  in  1  kill current MEM-stage instruction.
- EX_MEM_alu_out  in  8  ALU result; also memory address.
- EX_MEM_B  in  8  store data.
- EX_MEM_shift_out  in  8  shifter result.
- EX_MEM_mem_write  in  1  store enable.
- EX_MEM_reg_write  in  1  register write enable.
- EX_MEM_reg_write_mux  in  2  write-back select.
- EX_MEM_rd  in  REG_ADDR_W  destination register.
- mem_fwd_data  out  8  combinational MEM-stage selected write-back data, for EX forwarding.
- MEM_WB_wb_data  out  8  registered write-back data.
- MEM_WB_reg_write  out  1  registered write enable.
- MEM_WB_rd  out  REG_ADDR_W  registered destination.
- mem_busy  out  1  memory unavailable; pipeline must stall.

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Write-back select encoding:
  - 2'b00 ALU.
  - 2'b01 memory read data.
  - 2'b10 shift_out.
  - 2'b11 reserved, selects ALU.
- mem_fwd_data = selected value, combinational, same cycle.
- Memory read:
  - Asynchronous, from current address.
  - Read-during-write to the same address returns old data; new data is visible the next cycle.
- Store: mem[addr] <= EX_MEM_B at the rising edge when EX_MEM_mem_write & !stall & !flush & !reset & !mem_busy.
- MEM/WB register, latency 1 cycle:
  - Loads {mem_fwd_data, EX_MEM_reg_write, EX_MEM_rd} each edge when !stall.
  - When stall is high it holds.
- flush: loads a bubble (wb_data 0, reg_write 0, rd 0) and suppresses the store. flush overrides stall.
- reset:
  - All MEM/WB outputs go to 0 the next edge; mem_busy = 0.
  - Memory contents are not reset.
  - A store in the same cycle as reset is dropped.
- Address wrap: upper alu_out bits above ADDR_W are ignored.

Optional Feature:
- Macro MEM_WB_MEM_CLEAR_EN.
- Defined:
  - Reset starts a 2-state FSM (IDLE, CLEAR) with an ADDR_W-bit counter.
  - The cycle after reset deasserts, the FSM is in CLEAR with counter 0. Each cycle it writes mem[cnt] <= 0 and increments cnt.
  - At cnt = 2**ADDR_W-1 it writes the last word and returns to IDLE.
  - mem_busy = 1 throughout CLEAR, i.e. exactly 2**ADDR_W cycles.
  - During CLEAR: stores are suppressed and MEM/WB loads bubbles.
  - Reset asserted mid-CLEAR restarts the clear from address 0 after release.
- Undefined: no FSM; mem_busy tied 0; memory content undefined until written.

Decomposition:
- Shared package mips_pkg:
  - WB_SEL_ALU, WB_SEL_MEM, WB_SEL_SHIFT localparams (2-bit).
  - DATA_W = 8.
  - Bubble constant for MEM/WB.
- Sub-module data_mem:
  - Parameters ADDR_W, DATA_W.
  - Ports: async read, synchronous write enable/address/data.
  - The clear FSM drives its write port through a mux in mem_wb_stage.
- MEM/WB register: existing M_S_FF with width 8+1+REG_ADDR_W.

Test Plan:
- Store-load, ADDR_W=8:
  - Cycle 1: mem_write=1, alu_out=8'h10, B=8'hA5.
  - Cycle 2: mux=01, alu_out=8'h10 -> mem_fwd_data=8'hA5 same cycle; MEM_WB_wb_data=8'hA5 next edge.
- Write-back mux: alu_out=8'h3C, shift_out=8'hF0. mux=00 -> 8'h3C; 10 -> 8'hF0; 11 -> 8'h3C. reg_write and rd=3'd5 propagate with 1-cycle latency.
- Stall:
  - Stall held 3 cycles during a store to 8'h20 with B=8'h11 and changing inputs -> MEM_WB outputs unchanged, mem[8'h20] unchanged.
  - Release -> store lands and register updates.
- Flush:
  - flush=1 with mem_write=1, reg_write=1 -> next edge MEM_WB_reg_write=0, wb_data=0; the following read of that address returns the prior value.
  - flush and stall together -> bubble loaded.
- Reset mid-stream: reset asserted while MEM_WB_wb_data=8'h77 -> next edge all MEM/WB outputs 0; a store in the reset cycle is not performed.
- Clear, with MEM_WB_MEM_CLEAR_EN, ADDR_W=4:
  - Preload mem[3]=8'hFF, then pulse reset -> mem_busy high exactly 16 cycles, mem[3]=0 afterwards.
  - Reset re-pulsed at cycle 5 of CLEAR -> busy for 16 cycles after the second release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit pipelined MIPS core: data width,
// write-back select encodings, MEM/WB bubble values and clear-FSM states.
package mips_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] WB_SEL_ALU   = 2'b00;
  localparam logic [1:0] WB_SEL_MEM   = 2'b01;
  localparam logic [1:0] WB_SEL_SHIFT = 2'b10;

  // Bubble contents for the MEM/WB register (rd bubble is all zeros).
  localparam logic [DATA_W-1:0] BUBBLE_WB_DATA   = 8'h00;
  localparam logic              BUBBLE_REG_WRITE = 1'b0;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

  // Write-back data select; the reserved code falls back to the ALU result.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem,
    input logic [DATA_W-1:0] shift
  );
    logic [DATA_W-1:0] res;
    case (sel)
      WB_SEL_ALU:   res = alu;
      WB_SEL_MEM:   res = mem;
      WB_SEL_SHIFT: res = shift;
      default:      res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/M_S_FF.sv
// Generic enabled pipeline register with synchronous active-high reset.
module M_S_FF #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register: clear on reset, load when enabled, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/data_mem.sv
// Data memory: asynchronous read, synchronous single-port write.
// A read of the address being written returns the old word this cycle.
module data_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Storage array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register of the 8-bit MIPS core.
// Optional macro MEM_WB_MEM_CLEAR_EN: after reset a clear FSM zeroes the
// whole data memory, holding mem_busy high for 2**ADDR_W cycles.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [7:0]            EX_MEM_alu_out,
  input  logic [7:0]            EX_MEM_B,
  input  logic [7:0]            EX_MEM_shift_out,
  input  logic                  EX_MEM_mem_write,
  input  logic                  EX_MEM_reg_write,
  input  logic [1:0]            EX_MEM_reg_write_mux,
  input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
  output logic [7:0]            mem_fwd_data,
  output logic [7:0]            MEM_WB_wb_data,
  output logic                  MEM_WB_reg_write,
  output logic [REG_ADDR_W-1:0] MEM_WB_rd,
  output logic                  mem_busy
);

  localparam int WB_W = DATA_W + 1 + REG_ADDR_W;

  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] rdata_s;
  logic              store_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              kill_s;
  logic              wb_en_s;
  logic [WB_W-1:0]   wb_d;
  logic [WB_W-1:0]   wb_q;

  // Upper address bits beyond the memory depth are ignored (wrap).
  assign addr_s     = EX_MEM_alu_out[ADDR_W-1:0];
  assign store_en_s = EX_MEM_mem_write & ~stall & ~flush & ~reset & ~mem_busy;

`ifdef MEM_WB_MEM_CLEAR_EN
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  clr_state_t        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              clearing_s;

  // Clear FSM: reset (re)arms CLEAR at address 0, then one word per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR_CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        CLR_CLEAR: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= CLR_IDLE;
          end else begin
            state_q <= CLR_CLEAR;
          end
        end
        default: begin
          state_q <= CLR_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign clearing_s = (state_q == CLR_CLEAR) & ~reset;
  assign mem_busy   = clearing_s;

  // Write-port mux: the clear FSM owns the port while clearing.
  always_comb begin
    mem_we_s    = store_en_s;
    mem_waddr_s = addr_s;
    mem_wdata_s = EX_MEM_B;
    if (clearing_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_q;
      mem_wdata_s = 8'h00;
    end else begin
      mem_we_s    = store_en_s;
      mem_waddr_s = addr_s;
      mem_wdata_s = EX_MEM_B;
    end
  end
`else
  assign mem_busy    = 1'b0;
  assign mem_we_s    = store_en_s;
  assign mem_waddr_s = addr_s;
  assign mem_wdata_s = EX_MEM_B;
`endif

  data_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_data_mem (
    .clk  (clk),
    .we   (mem_we_s),
    .waddr(mem_waddr_s),
    .wdata(mem_wdata_s),
    .raddr(addr_s),
    .rdata(rdata_s)
  );

  assign mem_fwd_data = wb_select(EX_MEM_reg_write_mux, EX_MEM_alu_out, rdata_s,
                                  EX_MEM_shift_out);

  // A killed instruction (flush or busy memory) loads a bubble, even under stall.
  assign kill_s  = flush | mem_busy;
  assign wb_en_s = ~stall | kill_s;

  // MEM/WB next value: bubble when killed, else the selected write-back data.
  always_comb begin
    wb_d = {mem_fwd_data, EX_MEM_reg_write, EX_MEM_rd};
    if (kill_s) begin
      wb_d = {BUBBLE_WB_DATA, BUBBLE_REG_WRITE, {REG_ADDR_W{1'b0}}};
    end else begin
      wb_d = {mem_fwd_data, EX_MEM_reg_write, EX_MEM_rd};
    end
  end

  M_S_FF #(.W(WB_W)) u_mem_wb (
    .clk  (clk),
    .reset(reset),
    .en   (wb_en_s),
    .d    (wb_d),
    .q    (wb_q)
  );

  assign MEM_WB_wb_data   = wb_q[WB_W-1 -: DATA_W];
  assign MEM_WB_reg_write = wb_q[REG_ADDR_W];
  assign MEM_WB_rd        = wb_q[REG_ADDR_W-1:0];

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

`ifdef MEM_WB_MEM_CLEAR_EN
  localparam int AW = 4;
`else
  localparam int AW = 8;
`endif

  logic       clk = 1'b0;
  logic       reset, stall, flush;
  logic [7:0] alu, bdat, shf;
  logic       mw, rw;
  logic [1:0] mux;
  logic [2:0] rd;
  logic [7:0] fwd, wb;
  logic       wb_rw, busy;
  logic [2:0] wb_rd;

  int total = 0;
  int bad   = 0;
  int nbusy;

  always #5 clk = ~clk;

  mem_wb_stage #(.ADDR_W(AW), .REG_ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .EX_MEM_alu_out(alu), .EX_MEM_B(bdat), .EX_MEM_shift_out(shf),
    .EX_MEM_mem_write(mw), .EX_MEM_reg_write(rw), .EX_MEM_reg_write_mux(mux),
    .EX_MEM_rd(rd), .mem_fwd_data(fwd), .MEM_WB_wb_data(wb),
    .MEM_WB_reg_write(wb_rw), .MEM_WB_rd(wb_rd), .mem_busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic [7:0] d, input logic w, input logic [2:0] r);
    chk({tag, "_data"}, wb, d);
    chk({tag, "_rw"}, {7'd0, wb_rw}, {7'd0, w});
    chk({tag, "_rd"}, {5'd0, wb_rd}, {5'd0, r});
  endtask

  // Counts busy cycles from now, bounded at 40 cycles.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) begin
        n++;
        step();
      end else begin
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    alu = 8'h00; bdat = 8'h00; shf = 8'h00;
    mw = 1'b0; rw = 1'b0; mux = 2'b00; rd = 3'd0;
    step();
    step();
    chk_wb("reset", 8'h00, 1'b0, 3'd0);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    reset = 1'b0;
`ifdef MEM_WB_MEM_CLEAR_EN
    #0;
    count_busy(nbusy);
    chk("init_clear_cycles", nbusy[7:0], 8'd16);
`endif

    // Store A5 to 0x10, then load it back.
    mw = 1'b1; alu = 8'h10; bdat = 8'hA5; mux = 2'b00;
    #1;
    chk("store_fwd_alu", fwd, 8'h10);
    step();
    mw = 1'b0; mux = 2'b01; rw = 1'b1; rd = 3'd2;
    #1;
    chk("load_fwd", fwd, 8'hA5);
    step();
    chk_wb("load_wb", 8'hA5, 1'b1, 3'd2);

    // Write-back mux.
    alu = 8'h3C; shf = 8'hF0; rd = 3'd5; rw = 1'b1; mux = 2'b00;
    #1;
    chk("mux00_fwd", fwd, 8'h3C);
    step();
    chk_wb("mux00_wb", 8'h3C, 1'b1, 3'd5);
    mux = 2'b10;
    #1;
    chk("mux10_fwd", fwd, 8'hF0);
    step();
    chk("mux10_wb", wb, 8'hF0);
    mux = 2'b11;
    #1;
    chk("mux11_fwd", fwd, 8'h3C);
    step();
    chk_wb("mux11_wb", 8'h3C, 1'b1, 3'd5);

    // Preload mem[0x20] = 99.
    mw = 1'b1; alu = 8'h20; bdat = 8'h99; mux = 2'b00; rw = 1'b0; rd = 3'd0;
    step();
    // wb now {20,0,0}; stall 3 cycles during a store of 11 to 0x20.
    stall = 1'b1; mw = 1'b1; alu = 8'h20; bdat = 8'h11; mux = 2'b01; rw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd = 3'(i + 1); shf = 8'(i);
      #1;
      chk("stall_mem_fwd", fwd, 8'h99);
      step();
      chk_wb("stall_hold", 8'h20, 1'b0, 3'd0);
    end
    stall = 1'b0; rd = 3'd6;
    #1;
    chk("release_fwd_old", fwd, 8'h99);
    step();
    chk_wb("release_wb", 8'h99, 1'b1, 3'd6);
    mw = 1'b0;
    #1;
    chk("release_store_landed", fwd, 8'h11);

    // Flush kills store and register write.
    flush = 1'b1; mw = 1'b1; rw = 1'b1; bdat = 8'hEE; rd = 3'd7;
    step();
    chk_wb("flush_bubble", 8'h00, 1'b0, 3'd0);
    flush = 1'b0; mw = 1'b0;
    #1;
    chk("flush_no_store", fwd, 8'h11);
    step();
    chk_wb("after_flush", 8'h11, 1'b1, 3'd7);
    flush = 1'b1; stall = 1'b1;
    step();
    chk_wb("flush_stall", 8'h00, 1'b0, 3'd0);
    flush = 1'b0; stall = 1'b0;

    // Reset mid-stream drops a same-cycle store.
    mux = 2'b00; alu = 8'h77; rw = 1'b1; rd = 3'd3;
    step();
    chk_wb("pre_reset", 8'h77, 1'b1, 3'd3);
    reset = 1'b1; mw = 1'b1; alu = 8'h20; bdat = 8'h55;
    step();
    chk_wb("mid_reset", 8'h00, 1'b0, 3'd0);
    reset = 1'b0; mw = 1'b0; mux = 2'b01;
    #1;
    chk("reset_store_dropped", fwd, 8'h11);

`ifdef MEM_WB_MEM_CLEAR_EN
    count_busy(nbusy);
    chk("reset_clear_cycles", nbusy[7:0], 8'd16);
    // Preload mem[3] = FF, then clear via reset pulse.
    mw = 1'b1; alu = 8'h03; bdat = 8'hFF; mux = 2'b00;
    step();
    mw = 1'b0; mux = 2'b01; alu = 8'h13;
    #1;
    chk("wrap_read_pre", fwd, 8'hFF);
    reset = 1'b1;
    step();
    chk("busy_in_reset", {7'd0, busy}, 8'h00);
    reset = 1'b0;
    #1;
    count_busy(nbusy);
    chk("clear_cycles", nbusy[7:0], 8'd16);
    alu = 8'h03;
    #1;
    chk("clear_mem3", fwd, 8'h00);
    // Reset re-pulsed at cycle 5 of CLEAR.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
    end
    chk("busy_mid_clear", {7'd0, busy}, 8'h01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    count_busy(nbusy);
    chk("reclear_cycles", nbusy[7:0], 8'd16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
